hamming_enc_seq: RTL and testbench
==================================

// Module: hamming_enc_seq
// PURPOSE
//  Hardware sequencer for the program-1 Hamming(16,11) encode job over the shared data memory.
//  On start it walks NUM_MSG packed 11-bit messages at SRC_BASE and writes 16-bit SECDED codewords at DST_BASE.
//  When the job completes it raises done.
//  Sits beside the core on the data-memory port; mem_gnt arbitrates port ownership cycle by cycle.
// PARAMETERS
//  NUM_MSG   15  messages per job (>=1)
//  SRC_BASE  0   byte address of message 0 low byte
//  DST_BASE  30  byte address of codeword 0 low byte
//  AW        8   memory address width
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-low; low forces IDLE immediately
//  start      in   1   job request, sampled in IDLE/DONE only
//  mem_gnt    in   1   memory port granted to this block this cycle
//  mem_rdata  in   8   combinational read data for mem_addr
//  mem_req    out  1   block wants the port (high in RD_*/WR_* states)
//  mem_addr   out  AW  byte address
//  mem_wr_en  out  1   write strobe; only ever high while mem_gnt=1
//  mem_wdata  out  8   write data
//  busy       out  1   job in progress
//  done       out  1   level; high from job end until next accepted start
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, idx=0, lo/hi regs=0, all outputs 0.
//  States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
//  IDLE/DONE --start--> RD_LO. On this edge: idx=0, done=0, busy=1.
//    start while busy is ignored.
//  RD_LO: addr=SRC_BASE+2*idx; if gnt, capture mem_rdata -> d[8:1], go RD_HI.
//  RD_HI: addr=SRC_BASE+2*idx+1; if gnt, capture mem_rdata[2:0] -> d[11:9], go WR_LO.
//    mem_rdata[7:3] is ignored.
//  WR_LO: addr=DST_BASE+2*idx, wr_en=gnt, wdata={d[4:2],p4,d[1],p2,p1,p0}; if gnt go WR_HI.
//  WR_HI: addr=DST_BASE+2*idx+1, wr_en=gnt, wdata={d[11:5],p8}; if gnt:
//    idx==NUM_MSG-1 -> DONE (busy=0, done=1)
//    else idx++ and go RD_LO.
//  gnt=0 in any RD_*/WR_* state: hold state and registers, wr_en=0, mem_req stays 1.
//  Parity (combinational from registered d):
//    p8 = ^d[11:5]
//    p4 = ^{d[11:8],d[4:2]}
//    p2 = ^{d[11],d[10],d[7],d[6],d[4],d[3],d[1]}
//    p1 = ^{d[11],d[9],d[7],d[5],d[4],d[2],d[1]}
//    p0 = ^d ^p8^p4^p2^p1 (overall parity)
//  Latency with gnt held high: 4 cycles per message.
//    Start edge to done high = 4*NUM_MSG cycles.
//  Addresses computed modulo 2^AW (wrap-around is not an error).
//  IDLE/DONE: mem_req=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
//  Reset mid-job: abort to IDLE with done=0.
//    Bytes already written stay written; no rollback.
//  idx width = $clog2(NUM_MSG+1); idx never exceeds NUM_MSG-1.
// TESTING
//  T1 all messages d=11'h000 ([0..29]=0), gnt=1, start pulse
//     -> [30..59]=8'h00; done high exactly 60 cycles after start edge.
//  T2 msg0 bytes {8'h07,8'hFF}
//     -> [30]=8'hFF, [31]=8'hFF.
//     msg1 bytes {8'h00,8'h01} (d=11'h001)
//     -> [32]=8'h0F, [33]=8'h00.
//  T3 msg0 hi byte 8'hF8, lo byte 8'h00 -> [30]=8'h00, [31]=8'h00 (junk bits [7:3] ignored).
//  T4 random 15 messages; gnt toggled pseudo-randomly ~50%
//     -> codewords match the reference formula; wr_en never high with gnt=0;
//        stalled cycles hold addr/state.
//  T5 reset=0 asserted asynchronously during WR_LO of msg 7
//     -> immediate IDLE, outputs 0; [30..43] valid, [44..59] untouched;
//        a new start re-runs the full job correctly.
//  T6 start pulses while busy -> ignored, no restart.
//     start in DONE -> done drops next cycle and the job reruns.

Source files
------------

// File: rtl/hamming_enc_seq.sv
// Hamming(16,11) SECDED encode sequencer: reads packed 11-bit messages from the
// shared data memory and writes 16-bit codewords back, one byte per granted cycle.
module hamming_enc_seq #(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          mem_gnt,
  input  logic [7:0]    mem_rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wdata,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(NUM_MSG + 1);
  localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A = AW'(DST_BASE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MSG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [7:0]    lo_q;
  logic [2:0]    hi_q;

  logic [11:1]   d;
  logic          p8, p4, p2, p1, p0;
  logic          start_ok;
  logic          last_msg;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          unused_rdata;

  // Only the low three bits of the high message byte carry data.
  assign unused_rdata = ^mem_rdata[7:3];

  assign start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
  assign last_msg = (idx_q == LAST_IDX);

  // Byte offsets are 2*idx; sums wrap modulo 2^AW by construction.
  assign src_addr = SRC_A + AW'({idx_q, 1'b0});
  assign dst_addr = DST_A + AW'({idx_q, 1'b0});

  assign d  = {hi_q, lo_q};
  assign p8 = ^d[11:5];
  assign p4 = ^{d[11:8], d[4:2]};
  assign p2 = ^{d[11], d[10], d[7], d[6], d[4], d[3], d[1]};
  assign p1 = ^{d[11], d[9], d[7], d[5], d[4], d[2], d[1]};
  assign p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
    end else begin
      if (start_ok) begin
        idx_q <= '0;
      end else if (state_q == S_WR_HI && mem_gnt && !last_msg) begin
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == S_RD_LO && mem_gnt) begin
        lo_q <= mem_rdata;
      end
      if (state_q == S_RD_HI && mem_gnt) begin
        hi_q <= mem_rdata[2:0];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)   state_d = S_RD_LO;
      S_RD_LO:        if (mem_gnt) state_d = S_RD_HI;
      S_RD_HI:        if (mem_gnt) state_d = S_WR_LO;
      S_WR_LO:        if (mem_gnt) state_d = S_WR_HI;
      S_WR_HI:        if (mem_gnt) state_d = last_msg ? S_DONE : S_RD_LO;
      default:        state_d = S_IDLE;
    endcase
  end

  // Stalled cycles (gnt=0) keep the request and address up but never write.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_RD_LO: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = src_addr;
      end
      S_RD_HI: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = src_addr + AW'(1);
      end
      S_WR_LO: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        mem_addr  = dst_addr;
        mem_wr_en = mem_gnt;
        mem_wdata = {d[4:2], p4, d[1], p2, p1, p0};
      end
      S_WR_HI: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        mem_addr  = dst_addr + AW'(1);
        mem_wr_en = mem_gnt;
        mem_wdata = {d[11:5], p8};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench for hamming_enc_seq: byte memory model, generic Hamming
// reference encoder, random data and random grant with directed corner cases.
module tb_hamming_enc_seq;

  localparam int NUM = 15;
  localparam int DST = 30;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mem_gnt;
  logic [7:0] mem_rdata;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       done;

  logic [7:0] rom  [256];
  logic [7:0] wmem [256];
  int         wcnt [256];
  logic       clr;

  int passed = 0;
  int total  = 0;
  int viol_wr = 0;
  int viol_hold = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_addr = '0;

  hamming_enc_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = rom[mem_addr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) begin
        wmem[i] <= 8'h00;
        wcnt[i] <= 0;
      end
    end else if (mem_wr_en) begin
      wmem[mem_addr] <= mem_wdata;
      wcnt[mem_addr] <= wcnt[mem_addr] + 1;
    end
  end

  always @(negedge clk) begin
    if (mem_wr_en && !mem_gnt) viol_wr++;
    if (prev_stall && mem_req && mem_addr !== prev_addr) viol_hold++;
    prev_stall = mem_req && !mem_gnt;
    prev_addr  = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Classic Hamming layout: data in non-power-of-two positions 1..15, parity at
  // powers of two covering positions with that bit set, overall parity at bit 0.
  function automatic logic [15:0] ref_cw(input logic [10:0] data);
    logic [15:0] cw;
    int k;
    logic par;
    cw = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = data[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++)
        if ((pos & p) != 0 && pos != p) par = par ^ cw[pos];
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  task automatic check_msgs(input string tag, input int first, input int last);
    logic [10:0] m;
    for (int i = first; i <= last; i++) begin
      m = {rom[2*i+1][2:0], rom[2*i]};
      check($sformatf("%s_cw%0d", tag, i), {16'h0, wmem[DST+2*i+1], wmem[DST+2*i]},
            {16'h0, ref_cw(m)});
    end
  endtask

  task automatic clear_mem();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done; cycles counts edges after the start edge.
  task automatic run_wait(input bit rand_gnt, input bit poke, input int budget,
                          output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      start   = poke && (cycles % 7 == 3);
      @(posedge clk); #1;
      cycles++;
    end
    start   = 1'b0;
    mem_gnt = 1'b1;
    if (!done) check("done_timeout", {31'h0, done}, 32'h1);
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_done);
    check({tag, "_req"},   {31'h0, mem_req}, 32'h0);
    check({tag, "_wr"},    {31'h0, mem_wr_en}, 32'h0);
    check({tag, "_addr"},  {24'h0, mem_addr}, 32'h0);
    check({tag, "_wdata"}, {24'h0, mem_wdata}, 32'h0);
    check({tag, "_busy"},  {31'h0, busy}, 32'h0);
    check({tag, "_done"},  {31'h0, done}, {31'h0, exp_done});
  endtask

  initial begin
    int cyc;
    int bad;
    reset   = 1'b0;
    start   = 1'b0;
    mem_gnt = 1'b0;
    clr     = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    #2;
    check_idle_outputs("reset", 1'b0);
    @(posedge clk); #1;
    clear_mem();
    reset = 1'b1;
    @(posedge clk); #1;

    // T1: all-zero messages, latency to done
    mem_gnt = 1'b1;
    pulse_start();
    check("t1_busy_after_start", {31'h0, busy}, 32'h1);
    run_wait(1'b0, 1'b0, 500, cyc);
    check("t1_latency", cyc, 60);
    check_msgs("t1", 0, NUM - 1);
    check_idle_outputs("t1_end", 1'b1);

    // T2: all-ones and single-bit messages
    clear_mem();
    rom[0] = 8'hFF; rom[1] = 8'h07;
    rom[2] = 8'h01; rom[3] = 8'h00;
    pulse_start();
    run_wait(1'b0, 1'b0, 500, cyc);
    check("t2_b30", {24'h0, wmem[30]}, 32'hFF);
    check("t2_b31", {24'h0, wmem[31]}, 32'hFF);
    check("t2_b32", {24'h0, wmem[32]}, 32'h0F);
    check("t2_b33", {24'h0, wmem[33]}, 32'h00);
    check_msgs("t2", 0, 1);

    // T3: junk in the unused high-byte bits
    clear_mem();
    rom[0] = 8'h00; rom[1] = 8'hF8;
    pulse_start();
    run_wait(1'b0, 1'b0, 500, cyc);
    check("t3_b30", {24'h0, wmem[30]}, 32'h00);
    check("t3_b31", {24'h0, wmem[31]}, 32'h00);

    // T4: random data, random grant
    clear_mem();
    for (int i = 0; i < 2 * NUM; i++) rom[i] = 8'($urandom);
    pulse_start();
    run_wait(1'b1, 1'b0, 3000, cyc);
    check_msgs("t4", 0, NUM - 1);
    check("t4_wr_without_gnt", viol_wr, 0);
    check("t4_stall_hold", viol_hold, 0);

    // T5: asynchronous reset during WR_LO of message 7
    clear_mem();
    for (int i = 0; i < 2 * NUM; i++) rom[i] = 8'($urandom);
    pulse_start();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_wr_en && mem_addr == 8'(DST + 14)) && cyc < 500);
    check("t5_reach_msg7", {31'h0, mem_wr_en}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("t5_abort", 1'b0);
    check_msgs("t5_partial", 0, 6);
    bad = 0;
    for (int a = DST + 14; a < DST + 30; a++) bad += wcnt[a];
    check("t5_untouched", bad, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_mem();
    pulse_start();
    run_wait(1'b0, 1'b0, 500, cyc);
    check("t5_rerun_latency", cyc, 60);
    check_msgs("t5_rerun", 0, NUM - 1);

    // T6: start while busy ignored; start in DONE reruns
    clear_mem();
    pulse_start();
    run_wait(1'b0, 1'b1, 500, cyc);
    check("t6_no_restart_latency", cyc, 60);
    bad = 0;
    for (int a = DST; a < DST + 30; a++) if (wcnt[a] != 1) bad++;
    check("t6_single_writes", bad, 0);
    check("t6_done_before", {31'h0, done}, 32'h1);
    pulse_start();
    check("t6_done_drops", {31'h0, done}, 32'h0);
    check("t6_busy_again", {31'h0, busy}, 32'h1);
    run_wait(1'b0, 1'b0, 500, cyc);
    check("t6_rerun_latency", cyc, 60);
    check_msgs("t6", 0, NUM - 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
